// File: rtl/cdc_bus_tx.sv
// Source-side 4-phase req/ack bus transmitter: holds a word on tx_data, raises tx_req, waits
// for synchronized ack, then return-to-zero. Optional phase timeout: CDC_BUS_TX_TIMEOUT_EN.
module cdc_bus_tx #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned SYNC_CYCLE     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             rx_ack,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDrop = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SYNC_CYCLE-1:0] sync_q;
    logic              ack_s;
    logic              tx_req_d;
    logic [WIDTH-1:0]  tx_data_d;
    logic              done_d;
    logic              err_d;
    logic              timeout;

    // rx_ack is asynchronous to clk; only the last stage is ever looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_CYCLE-2:0], rx_ack};
        end
    end

    assign ack_s = sync_q[SYNC_CYCLE-1];

`ifdef CDC_BUS_TX_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Fires on the edge at which the phase count would reach TIMEOUT_CYCLES-1.
    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 2));

    always_comb begin
        cnt_d = '0;
        if (state_q != StIdle && state_d == state_q) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tx_req_d  = tx_req;
        tx_data_d = tx_data;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    tx_data_d = in_data;
                    tx_req_d  = 1'b1;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StDrop;
                end else if (timeout) begin
                    tx_req_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StIdle;
                end
            end
            StDrop: begin
                if (!ack_s) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tx_req  <= 1'b0;
            tx_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_req  <= tx_req_d;
            tx_data <= tx_data_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    assign in_ready = (state_q == StIdle);

endmodule
